// File: rtl/uart_pkg.sv
// UART shared types and constants.
// Parity support is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  localparam int UART_DEFAULT_CLK_PER_BIT = 432;
  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time down-counter: load reloads CLK_PER_BIT-1,
// tick is high while the count sits at zero.
module uart_baud_cnt #(
  parameter int CLK_PER_BIT = 432
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);

  localparam int CW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, LSB first, valid/ready input.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_DEFAULT_CLK_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   tx_done
);

  generate
    if (CLK_PER_BIT < 2 || CLK_PER_BIT > 65535) begin : g_bad_cpb
      $error("uart_tx: CLK_PER_BIT must be in 2..65535");
    end
  endgenerate

  uart_state_e state_q, state_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0] idx_q, idx_d;
  logic tx_q, tx_d;
  logic load;
  logic tick;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif

  uart_baud_cnt #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          state_d = ST_START;
          shreg_d = tx_data;
          idx_d   = 3'd0;
          tx_d    = 1'b0;
          load    = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
          load    = 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          load = 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shreg_d = {1'b0, shreg_q[UART_DATA_W-1:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          load    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx_done  = (state_q == ST_STOP) && tick;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLK_PER_BIT=4.
// Frames are compared cycle by cycle against a bit-time line model.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int total = 0;
  int bad = 0;

  uart_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line level k cycles after the handshake edge.
  function automatic logic model_bit(input logic [7:0] d, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Raise tx_valid and wait (bounded) until the next edge is a handshake.
  task automatic offer(input logic [7:0] d, output bit ok);
    int n;
    n = 0;
    tx_valid = 1'b1;
    tx_data = d;
    while (!tx_ready && n < 100) begin
      step();
      n++;
    end
    ok = tx_ready;
    if (!ok) begin
      tx_valid = 1'b0;
      chk("ready_timeout", 32'(tx_ready), 32'd1);
    end
  endtask

  // Assumes the next posedge is the handshake for byte d.
  task automatic check_frame(input logic [7:0] d, input logic [7:0] exp_b,
                             input bit hold, input logic [7:0] nxt,
                             input int glitch_at);
    int wrong, first_bad, done_n, done_at;
    bit busy_ok;
    logic [7:0] dec;
    wrong = 0; first_bad = -1; done_n = 0; done_at = -1;
    busy_ok = 1'b1; dec = 8'h00;
    for (int k = 0; k < FL; k++) begin
      step();
      if (tx !== model_bit(d, k)) begin
        wrong++;
        if (first_bad < 0) first_bad = k;
      end
      if (tx_done === 1'b1) begin
        done_n++;
        done_at = k;
      end
      if (tx_ready !== 1'b0 || tx_busy !== 1'b1) busy_ok = 1'b0;
      if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= 8)
        dec[k/CPB-1] = tx;
      if (k == 0) begin
        tx_valid = hold;
        tx_data = hold ? nxt : 8'($urandom);
      end
      if (k == glitch_at) begin
        tx_valid = 1'b1;
        tx_data = 8'hFF;
      end
      if (k == glitch_at + 1) tx_valid = 1'b0;
    end
    chk($sformatf("wave_%02h_bad_cycles(first=%0d)", d, first_bad),
        32'(wrong), 32'd0);
    chk($sformatf("done_%02h_cycle", d), 32'(done_at), 32'(FL - 1));
    chk($sformatf("done_%02h_count", d), 32'(done_n), 32'd1);
    chk($sformatf("busy_%02h", d), 32'(busy_ok), 32'd1);
    chk($sformatf("decode_%02h", d), 32'(dec), 32'(exp_b));
    step();
    chk($sformatf("idle_%02h_ready_tx_busy", d),
        {29'd0, tx_ready, tx, tx_busy}, 32'b110);
  endtask

  initial begin
    bit ok;
    int stray;
    tbl[0] = '{8'h55, 8'h55};
    tbl[1] = '{8'hA5, 8'hA5};
    tbl[2] = '{8'h3C, 8'h3C};
    tbl[3] = '{8'h07, 8'h07};
    tbl[4] = '{8'h03, 8'h03};
    tbl[5] = '{8'h00, 8'h00};
    tbl[6] = '{8'hFF, 8'hFF};
    tbl[7] = '{8'h81, 8'h81};

    repeat (3) step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();
    chk("post_rst_idle", {30'd0, tx, tx_ready}, 32'b11);

    foreach (tbl[i]) begin
      offer(tbl[i].data, ok);
      if (ok) check_frame(tbl[i].data, tbl[i].exp_byte, 1'b0, 8'h00, -10);
      repeat (2) step();
    end

    // Back-to-back with tx_valid held; exactly one idle cycle between.
    offer(8'hA5, ok);
    if (ok) begin
      check_frame(8'hA5, 8'hA5, 1'b1, 8'h3C, -10);
      check_frame(8'h3C, 8'h3C, 1'b0, 8'h00, -10);
    end
    repeat (2) step();

    // Valid pulse with 0xFF during DATA must be ignored.
    offer(8'h00, ok);
    if (ok) begin
      check_frame(8'h00, 8'h00, 1'b0, 8'h00, 5 * CPB);
      stray = 0;
      for (int k = 0; k < 3 * CPB; k++) begin
        step();
        if (tx_ready !== 1'b1 || tx !== 1'b1) stray++;
      end
      chk("no_second_frame", 32'(stray), 32'd0);
    end

    // Asynchronous reset during bit 3 of 0x81.
    offer(8'h81, ok);
    if (ok) begin
      repeat (4 * CPB + 2) step();
      tx_valid = 1'b0;
      chk("pre_abort_busy", 32'(tx_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_tx", 32'(tx), 32'd1);
      chk("abort_ready", 32'(tx_ready), 32'd1);
      chk("abort_busy_done", {30'd0, tx_busy, tx_done}, 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (2) step();
      offer(8'h81, ok);
      if (ok) check_frame(8'h81, 8'h81, 1'b0, 8'h00, -10);
    end

    // Random bytes with random idle gaps.
    for (int r = 0; r < 20; r++) begin
      logic [7:0] d;
      d = 8'($urandom);
      repeat ($urandom_range(0, 5)) step();
      offer(d, ok);
      if (ok) check_frame(d, d, 1'b0, 8'h00, -10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
